// File: rtl/io_bus_if.sv
// I/O-cycle control strobes of the i8080-style CPU bus.
// The tri-state data bus stays a plain inout on the block.
interface io_bus_if;
  logic [7:0] io_addr;
  logic       write_io;
  logic       read_io;

  modport master (
    output io_addr,
    output write_io,
    output read_io
  );

  modport slave (
    input io_addr,
    input write_io,
    input read_io
  );
endinterface

// File: rtl/io_shift_unit.sv
// Byte-window barrel shifter on the CPU I/O bus with
// bit-reverse, auto-advancing offset and a fill counter.
module io_shift_unit #(
  parameter int         XLEN        = 8,
  parameter int         DEPTH       = 2,
  parameter logic [7:0] AMOUNT_PORT = 8'h02,
  parameter logic [7:0] DATA_PORT   = 8'h04,
  parameter logic [7:0] RESULT_PORT = 8'h03,
  parameter logic [7:0] MODE_PORT   = 8'h05,
  parameter logic [7:0] STATUS_PORT = 8'h06,
  parameter int         AW = $clog2(XLEN*(DEPTH-1))
) (
  input  logic           clk,
  input  logic           rst_n,
  io_bus_if.slave        bus,
  inout  tri [XLEN-1:0]  data
);

  localparam int WW   = DEPTH * XLEN;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int LAST = XLEN * (DEPTH - 1) - 1;

  logic [WW-1:0]   win;
  logic [AW-1:0]   offset;
  logic [1:0]      mode;
  logic [CW-1:0]   fill;
  logic            rd_q;

  logic            wr_data;
  logic            wr_amt;
  logic            wr_mode;
  logic            rd_res;
  logic            rd_stat;
  logic            fire;
  logic [WW-1:0]   shl;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] res;
  logic [XLEN-1:0] dout;
  logic            oe;

  assign wr_data = bus.write_io && (bus.io_addr == DATA_PORT);
  assign wr_amt  = bus.write_io && (bus.io_addr == AMOUNT_PORT);
  assign wr_mode = bus.write_io && (bus.io_addr == MODE_PORT);
  assign rd_res  = bus.read_io && (bus.io_addr == RESULT_PORT);
  assign rd_stat = bus.read_io && (bus.io_addr == STATUS_PORT);

  // End of a result read: strobe was seen last cycle, gone now.
  assign fire = rd_q && !rd_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win    <= '0;
      offset <= '0;
      mode   <= '0;
      fill   <= '0;
      rd_q   <= 1'b0;
    end else begin
      rd_q <= rd_res;
      if (wr_data) begin
        win <= {data, win[WW-1:XLEN]};
        if (fill != CW'(DEPTH))
          fill <= fill + CW'(1);
      end
      if (wr_mode)
        mode <= data[1:0];
      if (wr_amt)
        offset <= data[AW-1:0];
      else if (fire && mode[1])
        offset <= (offset == AW'(LAST)) ? '0 : offset + AW'(1);
    end
  end

  assign shl = win << offset;
  assign raw = XLEN'(shl >> (WW - XLEN));

  always_comb begin
    res = raw;
    if (mode[0])
      for (int i = 0; i < XLEN; i++)
        res[i] = raw[XLEN-1-i];
  end

  always_comb begin
    dout = '0;
    oe   = 1'b0;
    unique case (1'b1)
      rd_res: begin
        dout = res;
        oe   = 1'b1;
      end
      rd_stat: begin
        dout = XLEN'(fill);
        oe   = 1'b1;
      end
      default: ;
    endcase
  end

  // rst_n gates the driver so reset releases the bus at once.
  assign data = (oe && rst_n) ? dout : {XLEN{1'bz}};

endmodule

// File: tb/tb_io_shift_unit.sv
// Directed bench: DEPTH=2 and DEPTH=4 units share one I/O bus.
// Pulled-up data buses read all ones when released.
module tb_io_shift_unit;

  logic clk;
  logic rst_n;
  logic [7:0] drv;
  logic drv_en;
  int total;
  int bad;

  tri1 [7:0] d2;
  tri1 [7:0] d4;

  io_bus_if bus ();

  assign d2 = drv_en ? drv : 8'hzz;
  assign d4 = drv_en ? drv : 8'hzz;

  io_shift_unit #(.XLEN(8), .DEPTH(2)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .data  (d2)
  );

  io_shift_unit #(.XLEN(8), .DEPTH(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .data  (d4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    bus.io_addr  = a;
    drv          = v;
    drv_en       = 1'b1;
    bus.write_io = 1'b1;
    @(negedge clk);
    bus.write_io = 1'b0;
    drv_en       = 1'b0;
    bus.io_addr  = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, input int n,
                    output logic [7:0] f2, output logic [7:0] f4,
                    output logic [7:0] l2);
    @(negedge clk);
    bus.io_addr = a;
    bus.read_io = 1'b1;
    #1;
    f2 = d2;
    f4 = d4;
    for (int i = 1; i < n; i++) @(posedge clk);
    #1;
    l2 = d2;
    @(negedge clk);
    bus.read_io = 1'b0;
    bus.io_addr = 8'h00;
  endtask

  logic [7:0] a2;
  logic [7:0] a4;
  logic [7:0] e2;

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    drv          = 8'h00;
    drv_en       = 1'b0;
    bus.io_addr  = 8'h00;
    bus.write_io = 1'b0;
    bus.read_io  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_z2", d2, 8'hFF);
    chk("idle_z4", d4, 8'hFF);
    rd(8'h03, 1, a2, a4, e2);
    chk("rst_res2", a2, 8'h00);
    chk("rst_res4", a4, 8'h00);
    rd(8'h06, 1, a2, a4, e2);
    chk("rst_stat2", a2, 8'h00);
    chk("rst_stat4", a4, 8'h00);

    wr(8'h04, 8'hAB);
    wr(8'h04, 8'hCD);
    wr(8'h02, 8'h03);
    rd(8'h03, 1, a2, a4, e2);
    chk("legacy2", a2, 8'h6D);
    chk("legacy4", a4, 8'h6D);
    rd(8'h06, 1, a2, a4, e2);
    chk("stat2", a2, 8'h02);

    wr(8'h05, 8'h01);
    wr(8'h02, 8'h00);
    rd(8'h03, 1, a2, a4, e2);
    chk("reverse", a2, 8'hB3);

    wr(8'h05, 8'h02);
    wr(8'h02, 8'h06);
    rd(8'h03, 3, a2, a4, e2);
    chk("adv_off6", a2, 8'h6A);
    chk("adv_hold6", e2, 8'h6A);
    rd(8'h03, 3, a2, a4, e2);
    chk("adv_off7", a2, 8'hD5);
    chk("adv_hold7", e2, 8'hD5);
    rd(8'h03, 3, a2, a4, e2);
    chk("adv_wrap0", a2, 8'hCD);
    rd(8'h03, 1, a2, a4, e2);
    chk("adv_off1", a2, 8'h9B);

    wr(8'h02, 8'h05);
    @(negedge clk);
    bus.io_addr = 8'h03;
    bus.read_io = 1'b1;
    #1;
    chk("col_off5", d2, 8'hB5);
    @(posedge clk);
    @(negedge clk);
    bus.read_io  = 1'b0;
    bus.io_addr  = 8'h02;
    drv          = 8'h02;
    drv_en       = 1'b1;
    bus.write_io = 1'b1;
    @(negedge clk);
    bus.write_io = 1'b0;
    drv_en       = 1'b0;
    bus.io_addr  = 8'h00;
    rd(8'h03, 2, a2, a4, e2);
    chk("col_wins", a2, 8'h36);

    @(negedge clk);
    bus.io_addr = 8'h03;
    bus.read_io = 1'b1;
    #1;
    chk("mid_read", d2, 8'h6D);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rel2", d2, 8'hFF);
    chk("rst_rel4", d4, 8'hFF);
    @(negedge clk);
    bus.read_io = 1'b0;
    bus.io_addr = 8'h00;
    rst_n = 1'b1;
    rd(8'h03, 1, a2, a4, e2);
    chk("post_res2", a2, 8'h00);
    rd(8'h06, 1, a2, a4, e2);
    chk("post_stat2", a2, 8'h00);
    chk("post_stat4", a4, 8'h00);

    for (int i = 1; i <= 5; i++) wr(8'h04, 8'(i));
    wr(8'h02, 8'h0C);
    rd(8'h03, 1, a2, a4, e2);
    chk("d4_res", a4, 8'h40);
    chk("d2_res", a2, 8'h50);
    rd(8'h06, 1, a2, a4, e2);
    chk("d4_sat", a4, 8'h04);
    chk("d2_sat", a2, 8'h02);

    wr(8'h07, 8'h55);
    rd(8'h07, 1, a2, a4, e2);
    chk("nomatch2", a2, 8'hFF);
    chk("nomatch4", a4, 8'hFF);
    rd(8'h03, 1, a2, a4, e2);
    chk("nomatch_res", a4, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
